// File: rtl/trigger_cluster.sv
// Multi-actor trigger controller: one trigger FSM per actor plus cluster-wide sleep/sync/quiesce logic.
// Optional statistics counters are built when TRIGGER_CLUSTER_STATS_EN is defined.
module trigger_cluster #(
  parameter int NUM_ACTORS     = 4,
  parameter int QUIESCE_ROUNDS = 1,
  parameter int CNT_W          = 32
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_done,
  output logic                        ap_ready,
  output logic                        ap_idle,
  input  logic [NUM_ACTORS-1:0]       external_enqueue,
  input  logic [32*NUM_ACTORS-1:0]    actor_return,
  input  logic [NUM_ACTORS-1:0]       actor_done,
  output logic [NUM_ACTORS-1:0]       actor_start,
  output logic [NUM_ACTORS-1:0]       sleep,
  output logic [NUM_ACTORS-1:0]       sync_wait,
  output logic [NUM_ACTORS-1:0]       sync_exec,
  output logic [CNT_W*NUM_ACTORS-1:0] exec_count,
  output logic [CNT_W-1:0]            sync_rounds
);

  localparam logic [31:0] RET_IDLE     = 32'd0;
  localparam logic [31:0] RET_EXECUTED = 32'd1;
  localparam logic [4:0]  Q_TARGET     = 5'(QUIESCE_ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LAUNCH, ST_CHECK, ST_SLEEP,
    ST_SYNC_LAUNCH, ST_SYNC_CHECK, ST_SYNC_WAIT, ST_SYNC_EXEC
  } state_t;

  state_t     state_r     [NUM_ACTORS];
  state_t     state_nxt_s [NUM_ACTORS];
  logic [3:0] q_cnt_r;
  logic [3:0] q_cnt_nxt_s;
  logic [4:0] cnt_inc_s;
  logic       all_idle_s, all_sleep_s, all_sync_s, all_wait_s;
  logic       last_round_s, start_accept_s;

  // Cluster conditions and per-actor status decoded from current states
  always_comb begin
    all_idle_s  = 1'b1;
    all_sleep_s = 1'b1;
    all_sync_s  = 1'b1;
    all_wait_s  = 1'b1;
    actor_start = {NUM_ACTORS{1'b0}};
    sleep       = {NUM_ACTORS{1'b0}};
    sync_wait   = {NUM_ACTORS{1'b0}};
    sync_exec   = {NUM_ACTORS{1'b0}};
    for (int i = 0; i < NUM_ACTORS; i++) begin
      all_idle_s     = all_idle_s  & (state_r[i] == ST_IDLE);
      all_sleep_s    = all_sleep_s & (state_r[i] == ST_SLEEP);
      all_sync_s     = all_sync_s  & ((state_r[i] == ST_SYNC_WAIT) | (state_r[i] == ST_SYNC_EXEC));
      all_wait_s     = all_wait_s  & (state_r[i] == ST_SYNC_WAIT);
      actor_start[i] = (state_r[i] == ST_LAUNCH) | (state_r[i] == ST_SYNC_LAUNCH);
      sleep[i]       = (state_r[i] == ST_SLEEP);
      sync_wait[i]   = (state_r[i] == ST_SYNC_WAIT);
      sync_exec[i]   = (state_r[i] == ST_SYNC_EXEC);
    end
  end

  assign cnt_inc_s      = {1'b0, q_cnt_r} + 5'd1;
  assign last_round_s   = (cnt_inc_s == Q_TARGET);
  assign start_accept_s = ap_start & all_idle_s;
  assign ap_idle        = all_idle_s;
  assign ap_done        = all_sync_s & all_wait_s & last_round_s;
  assign ap_ready       = ap_done;

  // Per-actor next-state logic and quiesce counter update
  always_comb begin
    q_cnt_nxt_s = q_cnt_r;
    if (all_sync_s) begin
      if (all_wait_s && !last_round_s) begin
        q_cnt_nxt_s = cnt_inc_s[3:0];
      end else begin
        q_cnt_nxt_s = 4'd0;
      end
    end else begin
      q_cnt_nxt_s = q_cnt_r;
    end
    for (int i = 0; i < NUM_ACTORS; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        ST_IDLE: begin
          if (start_accept_s) state_nxt_s[i] = ST_LAUNCH;
          else                state_nxt_s[i] = ST_IDLE;
        end
        ST_LAUNCH, ST_CHECK: begin
          if (!actor_done[i])
            state_nxt_s[i] = ST_CHECK;
          else if (actor_return[32*i +: 32] == RET_IDLE)
            state_nxt_s[i] = ST_SLEEP;
          else if ((actor_return[32*i +: 32] == RET_EXECUTED) || external_enqueue[i])
            state_nxt_s[i] = ST_LAUNCH;
          else
            state_nxt_s[i] = ST_SLEEP;
        end
        ST_SLEEP: begin
          if (all_sleep_s) state_nxt_s[i] = ST_SYNC_LAUNCH;
          else             state_nxt_s[i] = ST_SLEEP;
        end
        ST_SYNC_LAUNCH, ST_SYNC_CHECK: begin
          if (!actor_done[i])
            state_nxt_s[i] = ST_SYNC_CHECK;
          else if (actor_return[32*i +: 32] == RET_EXECUTED)
            state_nxt_s[i] = ST_SYNC_EXEC;
          else
            state_nxt_s[i] = ST_SYNC_WAIT;
        end
        ST_SYNC_WAIT, ST_SYNC_EXEC: begin
          // Release is collective: every actor leaves the sync barrier together
          if (!all_sync_s)        state_nxt_s[i] = state_r[i];
          else if (!all_wait_s)   state_nxt_s[i] = ST_LAUNCH;
          else if (last_round_s)  state_nxt_s[i] = ST_IDLE;
          else                    state_nxt_s[i] = ST_SYNC_LAUNCH;
        end
        default: state_nxt_s[i] = ST_IDLE;
      endcase
    end
  end

  // State and quiesce counter registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      q_cnt_r <= 4'd0;
      for (int i = 0; i < NUM_ACTORS; i++) state_r[i] <= ST_IDLE;
    end else begin
      q_cnt_r <= q_cnt_nxt_s;
      for (int i = 0; i < NUM_ACTORS; i++) state_r[i] <= state_nxt_s[i];
    end
  end

`ifdef TRIGGER_CLUSTER_STATS_EN
  logic [NUM_ACTORS-1:0] exec_done_s;
  logic [CNT_W-1:0]      exec_cnt_r [NUM_ACTORS];
  logic [CNT_W-1:0]      rounds_r;

  // EXECUTED completions seen in any launch/check state
  always_comb begin
    exec_done_s = {NUM_ACTORS{1'b0}};
    for (int i = 0; i < NUM_ACTORS; i++) begin
      case (state_r[i])
        ST_LAUNCH, ST_CHECK, ST_SYNC_LAUNCH, ST_SYNC_CHECK:
          exec_done_s[i] = actor_done[i] & (actor_return[32*i +: 32] == RET_EXECUTED);
        default:
          exec_done_s[i] = 1'b0;
      endcase
    end
  end

  // Statistics counters, cleared when a new run is accepted
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rounds_r <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_ACTORS; i++) exec_cnt_r[i] <= {CNT_W{1'b0}};
    end else if (start_accept_s) begin
      rounds_r <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_ACTORS; i++) exec_cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      if (all_sync_s) rounds_r <= rounds_r + CNT_W'(1);
      else            rounds_r <= rounds_r;
      for (int i = 0; i < NUM_ACTORS; i++) begin
        if (exec_done_s[i] && (exec_cnt_r[i] != {CNT_W{1'b1}}))
          exec_cnt_r[i] <= exec_cnt_r[i] + CNT_W'(1);
        else
          exec_cnt_r[i] <= exec_cnt_r[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_ACTORS; g++) begin : g_exec_out
    assign exec_count[CNT_W*g +: CNT_W] = exec_cnt_r[g];
  end
  assign sync_rounds = rounds_r;
`else
  assign exec_count  = {(CNT_W*NUM_ACTORS){1'b0}};
  assign sync_rounds = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_trigger_cluster.sv
// Directed table-driven bench for trigger_cluster: a 2-actor instance with one quiesce round
// and a 2-actor instance with three quiesce rounds.
module tb_trigger_cluster;

`ifdef TRIGGER_CLUSTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [31:0] W = 32'd2;  // neither IDLE nor EXECUTED
  localparam logic [31:0] X = 32'd1;  // EXECUTED
  localparam logic [31:0] I = 32'd0;  // IDLE

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Instance A: QUIESCE_ROUNDS = 1
  logic        a_start = 1'b0, a_done, a_ready, a_idle;
  logic [1:0]  a_enq = 2'b00, a_adone = 2'b00, a_astart, a_sleep, a_sw, a_se;
  logic [63:0] a_ret = 64'd0, a_exec;
  logic [31:0] a_rounds;

  trigger_cluster #(.NUM_ACTORS(2), .QUIESCE_ROUNDS(1), .CNT_W(32)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(a_start), .ap_done(a_done),
    .ap_ready(a_ready), .ap_idle(a_idle), .external_enqueue(a_enq), .actor_return(a_ret),
    .actor_done(a_adone), .actor_start(a_astart), .sleep(a_sleep), .sync_wait(a_sw),
    .sync_exec(a_se), .exec_count(a_exec), .sync_rounds(a_rounds)
  );

  // Instance B: QUIESCE_ROUNDS = 3
  logic        b_start = 1'b0, b_done, b_ready, b_idle;
  logic [1:0]  b_enq = 2'b00, b_adone = 2'b00, b_astart, b_sleep, b_sw, b_se;
  logic [63:0] b_ret = 64'd0, b_exec;
  logic [31:0] b_rounds;

  trigger_cluster #(.NUM_ACTORS(2), .QUIESCE_ROUNDS(3), .CNT_W(32)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(b_start), .ap_done(b_done),
    .ap_ready(b_ready), .ap_idle(b_idle), .external_enqueue(b_enq), .actor_return(b_ret),
    .actor_done(b_adone), .actor_start(b_astart), .sleep(b_sleep), .sync_wait(b_sw),
    .sync_exec(b_se), .exec_count(b_exec), .sync_rounds(b_rounds)
  );

  typedef struct {
    logic        start;
    logic [1:0]  enq;
    logic [31:0] r0, r1;
    logic [1:0]  done;
    logic [1:0]  e_start, e_sleep, e_sw, e_se;
    logic        e_done, e_idle;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic st, input logic [1:0] enq, input logic [31:0] r0,
                              input logic [31:0] r1, input logic [1:0] dn,
                              input logic [1:0] es, input logic [1:0] esl, input logic [1:0] esw,
                              input logic [1:0] ese, input logic ed, input logic ei);
    vec_t v;
    v.start = st; v.enq = enq; v.r0 = r0; v.r1 = r1; v.done = dn;
    v.e_start = es; v.e_sleep = esl; v.e_sw = esw; v.e_se = ese; v.e_done = ed; v.e_idle = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Per cycle: expected outputs reflect the current state; inputs apply at the following edge
    vecs[0]  = mk(1'b1, 2'b00, W, W, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    vecs[1]  = mk(1'b0, 2'b00, W, W, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 2'b00, W, W, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 2'b00, W, W, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 2'b00, W, W, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 2'b00, W, W, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 2'b00, W, W, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 2'b10, X, W, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 2'b10, X, I, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 2'b00, X, W, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 2'b00, X, W, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 2'b00, W, X, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 2'b00, W, W, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 2'b00, W, X, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 2'b00, W, W, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 2'b11, W, W, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 2'b00, W, W, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 2'b00, W, W, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 2'b00, W, W, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[19] = mk(1'b0, 2'b00, W, W, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    vecs[20] = mk(1'b0, 2'b00, W, W, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);

    repeat (3) @(negedge ap_clk);
    chk("reset exec_count", a_exec, 64'd0);
    chk("reset sync_rounds", {32'd0, a_rounds}, 64'd0);
    ap_rst_n = 1'b1;

    // Instance A: table of single-cycle vectors
    for (int k = 0; k < NV; k++) begin
      @(negedge ap_clk);
      chk($sformatf("v%0d actor_start", k), {62'd0, a_astart}, {62'd0, vecs[k].e_start});
      chk($sformatf("v%0d sleep", k),       {62'd0, a_sleep},  {62'd0, vecs[k].e_sleep});
      chk($sformatf("v%0d sync_wait", k),   {62'd0, a_sw},     {62'd0, vecs[k].e_sw});
      chk($sformatf("v%0d sync_exec", k),   {62'd0, a_se},     {62'd0, vecs[k].e_se});
      chk($sformatf("v%0d ap_done", k),     {63'd0, a_done},   {63'd0, vecs[k].e_done});
      chk($sformatf("v%0d ap_ready", k),    {63'd0, a_ready},  {63'd0, vecs[k].e_done});
      chk($sformatf("v%0d ap_idle", k),     {63'd0, a_idle},   {63'd0, vecs[k].e_idle});
      a_start = vecs[k].start;
      a_enq   = vecs[k].enq;
      a_ret   = {vecs[k].r1, vecs[k].r0};
      a_adone = vecs[k].done;
    end
    @(negedge ap_clk);
    chk("stats exec_count[0]", {32'd0, a_exec[31:0]},  STATS ? 64'd3 : 64'd0);
    chk("stats exec_count[1]", {32'd0, a_exec[63:32]}, STATS ? 64'd1 : 64'd0);
    chk("stats sync_rounds",   {32'd0, a_rounds},      STATS ? 64'd2 : 64'd0);

    // Asynchronous reset while actors are launching
    a_start = 1'b1; a_adone = 2'b00;
    @(negedge ap_clk);
    a_start = 1'b0;
    chk("pre-reset actor_start", {62'd0, a_astart}, 64'd3);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("async reset actor_start", {62'd0, a_astart}, 64'd0);
    chk("async reset ap_idle", {63'd0, a_idle}, 64'd1);
    chk("async reset exec_count", a_exec, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post-reset ap_idle", {63'd0, a_idle}, 64'd1);
    a_start = 1'b1;
    @(negedge ap_clk);
    a_start = 1'b0;
    chk("restart actor_start", {62'd0, a_astart}, 64'd3);
    a_adone = 2'b11; a_ret = {W, W};
    @(negedge ap_clk);
    a_adone = 2'b00;
    chk("restart sleep", {62'd0, a_sleep}, 64'd3);

    // Instance B: two all-wait rounds, one round with EXECUTED, then three all-wait rounds
    b_start = 1'b1;
    @(negedge ap_clk);
    b_start = 1'b0;
    chk("B launch", {62'd0, b_astart}, 64'd3);
    b_adone = 2'b11; b_ret = {W, W};
    @(negedge ap_clk);
    b_adone = 2'b00;
    chk("B sleep", {62'd0, b_sleep}, 64'd3);
    for (int r = 0; r < 3; r++) begin
      @(negedge ap_clk);
      chk($sformatf("B r%0d sync_launch", r), {62'd0, b_astart}, 64'd3);
      b_adone = 2'b11; b_ret = {W, (r == 2) ? X : W};
      @(negedge ap_clk);
      b_adone = 2'b00;
      chk($sformatf("B r%0d ap_done", r), {63'd0, b_done}, 64'd0);
    end
    @(negedge ap_clk);
    chk("B relaunch after exec", {62'd0, b_astart}, 64'd3);
    chk("B relaunch not sync", {62'd0, b_sw | b_se}, 64'd0);
    b_adone = 2'b11; b_ret = {W, W};
    @(negedge ap_clk);
    b_adone = 2'b00;
    chk("B sleep 2", {62'd0, b_sleep}, 64'd3);
    for (int r = 0; r < 3; r++) begin
      @(negedge ap_clk);
      chk($sformatf("B q%0d sync_launch", r), {62'd0, b_astart}, 64'd3);
      b_adone = 2'b11; b_ret = {W, W};
      @(negedge ap_clk);
      b_adone = 2'b00;
      chk($sformatf("B q%0d ap_done", r), {63'd0, b_done}, (r == 2) ? 64'd1 : 64'd0);
    end
    @(negedge ap_clk);
    chk("B final ap_idle", {63'd0, b_idle}, 64'd1);
    chk("B exec_count[0]", {32'd0, b_exec[31:0]}, STATS ? 64'd1 : 64'd0);
    chk("B sync_rounds", {32'd0, b_rounds}, STATS ? 64'd6 : 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
